led_matrix_scan: RTL and testbench



---
 rtl/led_matrix_scan.sv | 130 +++++++++++++
 tb/tb_led_matrix_scan.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan.sv
// Row-scanning controller for a 4x4 LED matrix with a shadow-buffered frame and dead-time blanking.
// Optional global brightness PWM is enabled by defining LED_SCAN_PWM_EN.
module led_matrix_scan #(
  parameter int DWELL_CYCLES = 12000,
  parameter int BLANK_CYCLES = 48
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_frame_in,
  input  logic        i_frame_valid,
  output logic        o_frame_ready,
  input  logic [3:0]  i_brightness,
  output logic [3:0]  o_kled_oe,
  output logic [3:0]  o_aled,
  output logic [1:0]  o_row_idx,
  output logic        o_frame_start
);

  localparam int MAXC  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW    = $clog2(MAXC + 1);
  localparam int SLICE = DWELL_CYCLES / 16;

  localparam logic [0:0] ST_BLANK  = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]    r_state;
  logic [CW-1:0] r_count;
  logic [15:0]   r_display;
  logic [15:0]   r_shadow;
  logic          r_full;

  logic [0:0]    w_next_state;
  logic [CW-1:0] w_next_count;
  logic [1:0]    w_next_row;
  logic [15:0]   w_next_display;
  logic [15:0]   w_next_shadow;
  logic          w_next_full;
  logic          w_blank_done;
  logic          w_active_done;
  logic          w_accept;
  logic          w_swap;
  logic [3:0]    w_row_data;
  logic          w_gate_on;

  // Next-state values are computed here so every output can be registered
  // in step with the state it describes.
  always_comb begin
    w_blank_done  = (r_state == ST_BLANK)  && (r_count == CW'(BLANK_CYCLES - 1));
    w_active_done = (r_state == ST_ACTIVE) && (r_count == CW'(DWELL_CYCLES - 1));
    w_accept      = i_frame_valid && !r_full;
    w_swap        = w_blank_done && (o_row_idx == 2'd0) && r_full;

    w_next_state = r_state;
    w_next_count = r_count + 1'b1;
    w_next_row   = o_row_idx;
    if (w_blank_done) begin
      w_next_state = ST_ACTIVE;
      w_next_count = '0;
    end else if (w_active_done) begin
      w_next_state = ST_BLANK;
      w_next_count = '0;
      w_next_row   = o_row_idx + 2'd1;
    end

    w_next_display = w_swap ? r_shadow : r_display;
    w_next_shadow  = w_accept ? i_frame_in : r_shadow;
    if (w_swap) begin
      w_next_full = 1'b0;
    end else if (w_accept) begin
      w_next_full = 1'b1;
    end else begin
      w_next_full = r_full;
    end

    w_row_data = w_next_display[{w_next_row, 2'b00} +: 4];
  end

`ifdef LED_SCAN_PWM_EN
  logic [3:0]    r_bl;
  logic [3:0]    w_next_bl;
  logic [CW-1:0] w_pwm_limit;

  // Brightness is latched only at the frame swap so duty never changes mid-frame.
  always_comb begin
    w_next_bl   = w_swap ? i_brightness : r_bl;
    w_pwm_limit = CW'((int'(w_next_bl) + 1) * SLICE);
    w_gate_on   = (w_next_count < w_pwm_limit);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bl <= 4'd15;
    end else begin
      r_bl <= w_next_bl;
    end
  end
`else
  logic w_unused_brightness;

  assign w_unused_brightness = ^i_brightness;
  assign w_gate_on           = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_BLANK;
      r_count       <= '0;
      r_display     <= '0;
      r_shadow      <= '0;
      r_full        <= 1'b0;
      o_row_idx     <= 2'd0;
      o_kled_oe     <= 4'd0;
      o_aled        <= 4'd0;
      o_frame_start <= 1'b0;
      o_frame_ready <= 1'b1;
    end else begin
      r_state       <= w_next_state;
      r_count       <= w_next_count;
      r_display     <= w_next_display;
      r_shadow      <= w_next_shadow;
      r_full        <= w_next_full;
      o_row_idx     <= w_next_row;
      o_kled_oe     <= (w_next_state == ST_ACTIVE) ? (4'b0001 << w_next_row) : 4'd0;
      o_aled        <= ((w_next_state == ST_ACTIVE) && w_gate_on) ? w_row_data : 4'd0;
      o_frame_start <= w_blank_done && (o_row_idx == 2'd0);
      o_frame_ready <= !w_next_full;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan against a cycle-count based reference model.
// Build with LED_SCAN_PWM_EN defined to exercise the brightness PWM expectations.
module tb_led_matrix_scan;

  localparam int DWELL  = 32;
  localparam int BLANK  = 4;
  localparam int ROWP   = DWELL + BLANK;
  localparam int FRAMEP = 4 * ROWP;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] frame;
  logic [3:0]  bri;
  logic        frameReady;
  logic [3:0]  kledOe;
  logic [3:0]  aled;
  logic [1:0]  rowIdx;
  logic        frameStart;

  int          nTests = 0;
  int          nFail  = 0;

  // Reference model: position in the scan follows purely from the cycle count since reset.
  int          mT;
  bit          mFull;
  logic [15:0] mShadow;
  logic [15:0] mDisplay;
  logic [3:0]  mBl;

  always #5 clk = ~clk;

  led_matrix_scan #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_frame_in(frame),
    .i_frame_valid(valid),
    .o_frame_ready(frameReady),
    .i_brightness(bri),
    .o_kled_oe(kledOe),
    .o_aled(aled),
    .o_row_idx(rowIdx),
    .o_frame_start(frameStart)
  );

  function automatic logic [11:0] obsVec();
    return {kledOe, aled, rowIdx, frameStart, frameReady};
  endfunction

  function automatic logic [11:0] expVec();
    int          pos;
    int          row;
    int          ac;
    logic [3:0]  k;
    logic [3:0]  a;
    logic [1:0]  r2;
    pos = mT % ROWP;
    row = (mT / ROWP) % 4;
    ac  = pos - BLANK;
    k   = 4'd0;
    a   = 4'd0;
    if (pos >= BLANK) begin
      k = 4'b0001 << row;
      a = mDisplay[row*4 +: 4];
`ifdef LED_SCAN_PWM_EN
      if (ac >= (int'(mBl) + 1) * (DWELL / 16)) a = 4'd0;
`endif
    end
    r2 = 2'(row);
    return {k, a, r2, ((mT % FRAMEP) == BLANK), !mFull};
  endfunction

  task automatic tick();
    logic        sRst;
    logic        sValid;
    logic [15:0] sFrame;
    logic [3:0]  sBri;
    bit          swap;
    sRst   = rst;
    sValid = valid;
    sFrame = frame;
    sBri   = bri;
    @(posedge clk);
    #1;
    if (sRst) begin
      mT       = 0;
      mFull    = 1'b0;
      mDisplay = 16'h0;
      mBl      = 4'd15;
    end else begin
      swap = ((mT % FRAMEP) == BLANK - 1) && mFull;
      if (swap) begin
        mDisplay = mShadow;
        mFull    = 1'b0;
        mBl      = sBri;
      end else if (sValid && !mFull) begin
        mShadow = sFrame;
        mFull   = 1'b1;
      end
      mT++;
    end
  endtask

  task automatic runTo(input int phase);
    int guard;
    guard = 0;
    while (((mT % FRAMEP) != phase) && (guard < FRAMEP + 2)) begin
      tick();
      guard++;
    end
  endtask

  task automatic test_reset();
    logic [3:0] expK;
    rst   = 1'b1;
    valid = 1'b0;
    frame = 16'h0;
    bri   = 4'd15;
    repeat (3) tick();
    rst = 1'b0;
    nTests++;
    if (obsVec() !== 12'h001) begin
      nFail++;
      $display("[TB] FAIL reset_state: got %h want %h", obsVec(), 12'h001);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      expK = (i == 4) ? 4'b0001 : 4'b0000;
      nTests++;
      if (kledOe !== expK || frameStart !== (i == 4)) begin
        nFail++;
        $display("[TB] FAIL reset_first_active c%0d: got kled=%b fs=%b want kled=%b fs=%b",
                 i, kledOe, frameStart, expK, (i == 4));
      end
    end
  endtask

  task automatic test_load();
    logic [3:0] expRow [4];
    expRow = '{4'h3, 4'hC, 4'h5, 4'hA};
    frame = 16'hA5C3;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    frame = 16'h0;
    nTests++;
    if (frameReady !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL load_ready_fall: got %b want 0", frameReady);
    end
    for (int r = 0; r < 4; r++) begin
      runTo(r * ROWP + BLANK);
      nTests++;
      if (aled !== expRow[r] || obsVec() !== expVec()) begin
        nFail++;
        $display("[TB] FAIL load_row%0d: got aled=%h vec=%h want aled=%h vec=%h",
                 r, aled, obsVec(), expRow[r], expVec());
      end
      if (r == 0) begin
        nTests++;
        if (frameReady !== 1'b1) begin
          nFail++;
          $display("[TB] FAIL load_ready_rise: got %b want 1", frameReady);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int waited;
    frame = 16'h0001;
    valid = 1'b1;
    tick();
    frame  = 16'hFFFF;
    waited = 0;
    while (frameReady !== 1'b1 && waited < 2 * FRAMEP) begin
      tick();
      waited++;
    end
    nTests++;
    if (frameReady !== 1'b1 || (mT % FRAMEP) != BLANK) begin
      nFail++;
      $display("[TB] FAIL b2b_ready_rise: got ready=%b phase=%0d want ready=1 phase=%0d",
               frameReady, mT % FRAMEP, BLANK);
    end
    nTests++;
    if (aled !== 4'h1) begin
      nFail++;
      $display("[TB] FAIL b2b_first_frame: got %h want 1", aled);
    end
    tick();
    valid = 1'b0;
    nTests++;
    if (frameReady !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL b2b_second_accept: got ready=%b want 0", frameReady);
    end
    runTo(BLANK);
    nTests++;
    if (aled !== 4'hF || frameReady !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL b2b_second_frame: got aled=%h ready=%b want aled=f ready=1",
               aled, frameReady);
    end
  endtask

  task automatic test_scan_order();
    runTo(0);
    for (int i = 0; i < FRAMEP; i++) begin
      nTests++;
      if (obsVec() !== expVec()) begin
        nFail++;
        $display("[TB] FAIL scan_c%0d: got %h want %h", i, obsVec(), expVec());
      end
      nTests++;
      if (!(kledOe inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000}) ||
          (kledOe == 4'b0000 && aled != 4'b0000)) begin
        nFail++;
        $display("[TB] FAIL scan_invariant_c%0d: got kled=%b aled=%b", i, kledOe, aled);
      end
      tick();
    end
  endtask

  task automatic test_pwm();
    logic [3:0] expA;
    bri   = 4'd3;
    frame = 16'hFFFF;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    runTo(BLANK);
    for (int c = 0; c < DWELL; c++) begin
`ifdef LED_SCAN_PWM_EN
      expA = (c < 8) ? 4'hF : 4'h0;
`else
      expA = 4'hF;
`endif
      nTests++;
      if (aled !== expA || kledOe !== 4'b0001) begin
        nFail++;
        $display("[TB] FAIL pwm_c%0d: got aled=%h kled=%b want aled=%h kled=0001",
                 c, aled, kledOe, expA);
      end
      tick();
    end
    bri = 4'd15;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      valid = 1'($urandom_range(0, 1));
      frame = 16'($urandom);
      bri   = 4'($urandom);
      rst   = ($urandom_range(0, 499) == 0);
      tick();
      nTests++;
      if (obsVec() !== expVec()) begin
        nFail++;
        $display("[TB] FAIL random_c%0d: got %h want %h", i, obsVec(), expVec());
      end
      nTests++;
      if (!(kledOe inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000}) ||
          (kledOe == 4'b0000 && aled != 4'b0000)) begin
        nFail++;
        $display("[TB] FAIL random_invariant_c%0d: got kled=%b aled=%b", i, kledOe, aled);
      end
    end
    rst   = 1'b0;
    valid = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    bri   = 4'd15;
    valid = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    runTo(10);
    frame = 16'h1234;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    runTo(BLANK);
    runTo(10);
    frame = 16'h5678;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    runTo(2 * ROWP + BLANK + 10);
    nTests++;
    if (obsVec() !== expVec() || frameReady !== 1'b0 || aled !== 4'h2) begin
      nFail++;
      $display("[TB] FAIL midrst_before: got %h want %h", obsVec(), expVec());
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nTests++;
    if (obsVec() !== 12'h001) begin
      nFail++;
      $display("[TB] FAIL midrst_after: got %h want %h", obsVec(), 12'h001);
    end
    runTo(BLANK);
    nTests++;
    if (kledOe !== 4'b0001 || aled !== 4'h0 || frameStart !== 1'b1 || frameReady !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL midrst_restart: got kled=%b aled=%h fs=%b ready=%b want 0001 0 1 1",
               kledOe, aled, frameStart, frameReady);
    end
  endtask

  initial begin
    mT       = 0;
    mFull    = 1'b0;
    mShadow  = 16'h0;
    mDisplay = 16'h0;
    mBl      = 4'd15;
    test_reset();
    test_load();
    test_back_to_back();
    test_scan_order();
    test_pwm();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
